// File: rtl/usb_pkt_buffer.sv
// Circular packet FIFO shared by the USB host side and bus side. Reads are first-word
// fall-through; overflow/underflow are sticky until clear or reset.
module usb_pkt_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     store_tx_data,
    input  logic                     store_rx_packet_data,
    input  logic                     get_tx_packet_data,
    input  logic                     get_rx_data,
    input  logic                     flush,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         tx_data,
    input  logic [WIDTH-1:0]         rx_packet_data,
    output logic [$clog2(DEPTH):0]   buffer_occupancy,
    output logic [WIDTH-1:0]         tx_packet_data,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_occ;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_discard;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_head;
    logic [AW:0]      w_occ_next;

    assign w_full    = (r_occ == FULL_CNT);
    assign w_empty   = (r_occ == {(AW+1){1'b0}});
    assign w_push    = store_tx_data | store_rx_packet_data;
    assign w_pop     = get_tx_packet_data | get_rx_data;
    assign w_discard = flush | clear;
    assign w_head    = r_mem[r_rptr];

    // Accept/reject decisions; a full buffer still takes a push when a pop frees a slot
    always_comb begin
        w_pop_ok   = w_pop & ~w_empty;
        w_push_ok  = w_push & (~w_full | w_pop_ok);
        w_wdata    = {WIDTH{1'b0}};
        w_occ_next = r_occ;
        if (store_tx_data) begin
            w_wdata = tx_data;
        end else begin
            w_wdata = rx_packet_data;
        end
        if (w_discard) begin
            w_occ_next = {(AW+1){1'b0}};
        end else if (w_push_ok && !w_pop_ok) begin
            w_occ_next = r_occ + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            w_occ_next = r_occ - 1'b1;
        end else begin
            w_occ_next = r_occ;
        end
    end

    // Head entry routed only to the selected read port, zero otherwise
    always_comb begin
        tx_packet_data = {WIDTH{1'b0}};
        rx_data        = {WIDTH{1'b0}};
        if (w_pop_ok && get_tx_packet_data) begin
            tx_packet_data = w_head;
        end else if (w_pop_ok && get_rx_data) begin
            rx_data = w_head;
        end else begin
            tx_packet_data = {WIDTH{1'b0}};
        end
    end

    // Storage array; contents are left stale on flush/clear
    always_ff @(posedge clk) begin
        if (w_push_ok && !w_discard) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr      <= {AW{1'b0}};
            r_rptr      <= {AW{1'b0}};
            r_occ       <= {(AW+1){1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_occ <= w_occ_next;
            if (w_discard) begin
                r_wptr <= {AW{1'b0}};
                r_rptr <= {AW{1'b0}};
            end else begin
                if (w_push_ok) r_wptr <= r_wptr + 1'b1;
                if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            end
            if (clear) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_overflow  <= r_overflow  | (w_push & ~w_push_ok);
                r_underflow <= r_underflow | (w_pop & ~w_pop_ok);
            end
        end
    end

    assign buffer_occupancy = r_occ;
    assign full             = w_full;
    assign empty            = w_empty;
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;

endmodule

// File: tb/tb_usb_pkt_buffer.sv
// Bench for usb_pkt_buffer: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_usb_pkt_buffer;
    localparam int DEPTH = 64;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic n_rst;
    logic store_tx_data, store_rx_packet_data, get_tx_packet_data, get_rx_data;
    logic flush, clear;
    logic [WIDTH-1:0] tx_data, rx_packet_data;
    logic [$clog2(DEPTH):0] buffer_occupancy;
    logic [WIDTH-1:0] tx_packet_data, rx_data;
    logic full, empty, overflow, underflow;

    int errors = 0;
    int checks = 0;

    usb_pkt_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .n_rst(n_rst),
        .store_tx_data(store_tx_data), .store_rx_packet_data(store_rx_packet_data),
        .get_tx_packet_data(get_tx_packet_data), .get_rx_data(get_rx_data),
        .flush(flush), .clear(clear),
        .tx_data(tx_data), .rx_packet_data(rx_packet_data),
        .buffer_occupancy(buffer_occupancy),
        .tx_packet_data(tx_packet_data), .rx_data(rx_data),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of stored bytes plus two sticky flags
    logic [WIDTH-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit push, pop, popped, pushed;
            push   = store_tx_data | store_rx_packet_data;
            pop    = get_tx_packet_data | get_rx_data;
            popped = pop && (q.size() > 0);
            pushed = push && ((q.size() < DEPTH) || popped);
            if (clear) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (push && !pushed) m_ovf = 1'b1;
                if (pop && !popped)  m_unf = 1'b1;
            end
            if (flush || clear) begin
                q.delete();
            end else begin
                if (popped) void'(q.pop_front());
                if (pushed) q.push_back(store_tx_data ? tx_data : rx_packet_data);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            logic [WIDTH-1:0] head, e_tx, e_rx;
            head = (q.size() > 0) ? q[0] : 8'h00;
            e_tx = (get_tx_packet_data && q.size() > 0) ? head : 8'h00;
            e_rx = (!get_tx_packet_data && get_rx_data && q.size() > 0) ? head : 8'h00;
            chk("occupancy", 32'(buffer_occupancy), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("tx_packet_data", 32'(tx_packet_data), 32'(e_tx));
            chk("rx_data", 32'(rx_data), 32'(e_rx));
        end
    end

    // One bus cycle starting just after a rising edge; returns the read outputs seen mid-cycle
    task automatic cyc(input logic stx, input logic srx, input logic gtx, input logic grx,
                       input logic fl, input logic cl, input logic [7:0] txd, input logic [7:0] rxd,
                       output logic [7:0] rtx, output logic [7:0] rrx);
        store_tx_data = stx; store_rx_packet_data = srx;
        get_tx_packet_data = gtx; get_rx_data = grx;
        flush = fl; clear = cl; tx_data = txd; rx_packet_data = rxd;
        #3;
        rtx = tx_packet_data;
        rrx = rx_data;
        @(posedge clk); #1;
        store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
        get_tx_packet_data = 1'b0; get_rx_data = 1'b0;
        flush = 1'b0; clear = 1'b0;
    endtask

    logic [7:0] rt, rr;

    task automatic push_tx(input logic [7:0] d);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d, 8'h00, rt, rr);
    endtask
    task automatic pop_rx(output logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, rt, rr);
        d = rr;
    endtask
    task automatic do_clear();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, rt, rr);
    endtask
    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) push_tx(base + 8'(i));
    endtask

    logic [7:0] d;

    initial begin
        n_rst = 1'b0;
        store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
        get_tx_packet_data = 1'b0; get_rx_data = 1'b0;
        flush = 1'b0; clear = 1'b0; tx_data = 8'h00; rx_packet_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_occ", 32'(buffer_occupancy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // basic order through the rx read port
        push_tx(8'hA1); push_tx(8'hB2); push_tx(8'hC3);
        chk("fifo3_occ", 32'(buffer_occupancy), 32'd3);
        pop_rx(d); chk("fifo3_pop0", 32'(d), 32'hA1);
        pop_rx(d); chk("fifo3_pop1", 32'(d), 32'hB2);
        pop_rx(d); chk("fifo3_pop2", 32'(d), 32'hC3);
        chk("fifo3_occ_end", 32'(buffer_occupancy), 32'd0);
        chk("fifo3_empty", 32'(empty), 32'd1);

        // fill to full, then one push too many
        fill(DEPTH, 8'h40);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_occ", 32'(buffer_occupancy), 32'd64);
        push_tx(8'hEE);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_occ", 32'(buffer_occupancy), 32'd64);
        for (int i = 0; i < DEPTH; i++) begin
            pop_rx(d);
            chk("full_drain", 32'(d), 32'(8'h40 + 8'(i)));
        end

        // simultaneous push/pop at full wraps around
        do_clear();
        fill(DEPTH, 8'h80);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, rt, rr);
        chk("pp_head", 32'(rr), 32'h80);
        chk("pp_occ", 32'(buffer_occupancy), 32'd64);
        chk("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < DEPTH; i++) pop_rx(d);
        pop_rx(d);
        chk("pp_wrap", 32'(d), 32'h5A);

        // pop on empty with a same-cycle push
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00, rt, rr);
        chk("unf_rx0", 32'(rr), 32'h00);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_occ", 32'(buffer_occupancy), 32'd1);
        pop_rx(d);
        chk("unf_next", 32'(d), 32'h33);

        // flush keeps flags, clear drops them
        do_clear();
        fill(DEPTH, 8'h00);
        push_tx(8'hFF);
        for (int i = 0; i < DEPTH - 10; i++) pop_rx(d);
        chk("fl_pre_occ", 32'(buffer_occupancy), 32'd10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, rt, rr);
        chk("fl_occ", 32'(buffer_occupancy), 32'd0);
        chk("fl_ovf", 32'(overflow), 32'd1);
        do_clear();
        chk("cl_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, rt, rr);
        chk("cl_wins", 32'(underflow), 32'd0);

        // both strobes asserted: tx side wins each time
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, rt, rr);
        chk("both_occ", 32'(buffer_occupancy), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, rt, rr);
        chk("both_tx", 32'(rt), 32'h11);
        chk("both_rx", 32'(rr), 32'h00);

        // reset mid-transfer discards everything
        fill(5, 8'h70);
        n_rst = 1'b0;
        #1;
        chk("midrst_occ", 32'(buffer_occupancy), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        @(posedge clk); #1;
        n_rst = 1'b1;
        pop_rx(d);
        chk("midrst_pop", 32'(d), 32'h00);
        chk("midrst_unf", 32'(underflow), 32'd1);

        // randomized traffic: push-heavy phase then pop-heavy phase
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            pw = (i < 1500) ? 70 : 30;
            pr = 100 - pw;
            cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < pr / 2, $urandom_range(0, 99) < pr,
                $urandom_range(0, 999) < 8, $urandom_range(0, 999) < 5,
                8'($urandom), 8'($urandom), rt, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usb_pkt_buffer.md
USB_PKT_BUFFER -- requirements
Module: usb_pkt_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 64, buffer entries; power of two, 4 to 256.
REQ-002 SHALL have parameter: WIDTH, 8, bits per entry.
REQ-003 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: store_tx_data  input  1  push tx_data.
REQ-006 SHALL have port: store_rx_packet_data  input  1  push rx_packet_data.
REQ-007 SHALL have port: get_tx_packet_data  input  1  pop head to tx_packet_data.
REQ-008 SHALL have port: get_rx_data  input  1  pop head to rx_data.
REQ-009 SHALL have port: flush  input  1  discard contents, keep error flags.
REQ-010 SHALL have port: clear  input  1  discard contents, clear error flags.
REQ-011 SHALL have port: tx_data  input  WIDTH  host-side write data.
REQ-012 SHALL have port: rx_packet_data  input  WIDTH  bus-side write data.
REQ-013 SHALL have port: buffer_occupancy  output  $clog2(DEPTH)+1  stored entry count, 0..DEPTH.
REQ-014 SHALL have port: tx_packet_data  output  WIDTH  head entry during tx pop, else 0.
REQ-015 SHALL have port: rx_data  output  WIDTH  head entry during rx pop, else 0.
REQ-016 SHALL have port: full  output  1  occupancy == DEPTH.
REQ-017 SHALL have port: empty  output  1  occupancy == 0.
REQ-018 SHALL have port: overflow  output  1  sticky, push attempted while full.
REQ-019 SHALL have port: underflow  output  1  sticky, pop attempted while empty.

Function
REQ-020 SHALL implement a circular FIFO: DEPTH x WIDTH storage, write pointer, read pointer, occupancy counter; no data shifting.
REQ-021 SHALL treat push = store_tx_data | store_rx_packet_data; store_tx_data wins when both asserted, only tx_data written.
REQ-022 SHALL treat pop = get_tx_packet_data | get_rx_data; get_tx_packet_data wins when both asserted, only tx_packet_data driven.
REQ-023 SHALL drive read outputs combinationally, same cycle as pop (first-word fall-through); non-selected read output = 0.
REQ-024 SHALL write at write pointer and advance it on an accepted push; advance read pointer on an accepted pop; pointers wrap DEPTH-1 -> 0.
REQ-025 SHALL update occupancy next edge: +1 push only, -1 pop only, unchanged push+pop or neither.
REQ-026 SHALL ignore push while full unless an accepted pop occurs same cycle; ignored push sets overflow, leaves storage/pointers/occupancy unchanged.
REQ-027 SHALL ignore pop while empty (push same cycle still accepted, occupancy -> 1); ignored pop sets underflow, drives read output 0.
REQ-028 SHALL, on flush or clear, set pointers and occupancy to 0 next edge, overriding push/pop same cycle; storage contents need not be cleared.
REQ-029 SHALL clear overflow/underflow only on clear or reset; flush leaves them; clear wins over a same-cycle error event.
REQ-030 SHALL derive full/empty combinationally from registered occupancy.

Reset
REQ-031 SHALL, with n_rst low, immediately force pointers, occupancy, overflow, underflow to 0; empty = 1, full = 0, read outputs 0.
REQ-032 SHALL, on reset mid-transfer, discard all entries; first pop after release sees empty behaviour.

Verification
REQ-033 SHALL cover: reset, push 0xA1,0xB2,0xC3 via store_tx_data, three get_rx_data pops -> rx_data 0xA1,0xB2,0xC3, occupancy 3->0, empty=1.
REQ-034 SHALL cover: DEPTH=64, fill 64 entries -> full=1, occupancy 64; 65th push -> overflow=1, occupancy 64, later pops return original 64 bytes in order.
REQ-035 SHALL cover: occupancy 64, simultaneous push 0x5A and pop -> occupancy 64, overflow 0, 0x5A returned as 64th subsequent pop (wrap-around).
REQ-036 SHALL cover: empty, pop+push 0x33 same cycle -> underflow=1, rx_data 0, occupancy 1, next pop returns 0x33.
REQ-037 SHALL cover: occupancy 10 with overflow=1, flush -> occupancy 0, overflow stays 1; then clear -> overflow 0.
REQ-038 SHALL cover: both store strobes (tx_data 0x11, rx_packet_data 0x22) and both get strobes -> 0x11 stored, only tx_packet_data driven.
